// File: rtl/if_stage.sv
// RV32I instruction fetch stage: owns the PC, drives a 1-cycle-latency
// instruction RAM and presents inst_id/pc_id to decode.
module if_stage #(
  parameter logic [29:0] RESET_PC = 30'h0,
  parameter int unsigned IADR_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_start,
  input  logic [29:0]       start_adr,
  input  logic              jmp_req,
  input  logic [29:0]       jmp_adr,
  input  logic              stall,
  input  logic              rst_pipe,
  output logic              imem_ren,
  output logic [IADR_W-1:0] imem_radr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst_id,
  output logic [29:0]       pc_id
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [29:0] pc_if_q;
  logic [29:0] pc_id_q;
  logic        valid_q;
  logic [31:0] inst_hold_q;
  logic        use_hold_q;

  assign imem_ren  = (state_q == RUN) & ~stall & ~jmp_req & ~rst_pipe;
  assign imem_radr = pc_if_q[IADR_W-1:0];
  assign inst_id   = use_hold_q ? inst_hold_q : (valid_q ? imem_rdata : NOP);
  assign pc_id     = pc_id_q;

  // Branch order encodes edge priority: flush/idle, redirect, stall, advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_if_q     <= RESET_PC;
      pc_id_q     <= RESET_PC;
      valid_q     <= 1'b0;
      inst_hold_q <= NOP;
      use_hold_q  <= 1'b0;
    end else if (rst_pipe || !cpu_start || state_q == IDLE) begin
      state_q    <= cpu_start ? RUN : IDLE;
      pc_if_q    <= start_adr;
      valid_q    <= 1'b0;
      use_hold_q <= 1'b0;
    end else if (jmp_req) begin
      pc_if_q    <= jmp_adr;
      valid_q    <= 1'b0;
      use_hold_q <= 1'b0;
    end else if (stall) begin
      // Capture once so decode keeps seeing the same word after the RAM output goes stale.
      if (!use_hold_q) begin
        inst_hold_q <= inst_id;
        use_hold_q  <= 1'b1;
      end
    end else begin
      pc_id_q    <= pc_if_q;
      pc_if_q    <= pc_if_q + 30'd1;
      valid_q    <= 1'b1;
      use_hold_q <= 1'b0;
    end
  end

endmodule
